cnn_cell_sequencer: RTL and testbench

- Sequences one shared cellular-network cell datapath over a ROWS x COLS grid for a programmable number of iterations.
- For each cell, fetches the 3x3 neighbourhood of inputs (U) and states (Y) from external memory, replacing out-of-grid neighbours with a boundary value, and presents them to the datapath.
- Captures the saturated datapath result and writes it to the next-state bank. The state memory is ping-ponged between iterations.
- Sits between the grid state/input RAMs and the single cell datapath instance (A/B templates and bias I are wired statically outside this block).

---
 rtl/cnn_cell_sequencer_if.sv | 35 +++
 rtl/cnn_cell_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_cnn_cell_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_cell_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : cnn_cell_sequencer_if
// Purpose  : Memory read/write and datapath bus between the CNN sequencer,
//            the ping-pong grid RAMs and the shared cell datapath.
// Revision : 1.0
// =============================================================================
interface cnn_cell_sequencer_if #(
   parameter int WIDTH = 9,
   parameter int AW    = 4
);
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic                 rd_bank;
   logic [WIDTH-1:0]     rd_y;
   logic [WIDTH-1:0]     rd_u;
   logic [9*WIDTH-1:0]   nb_y;
   logic [9*WIDTH-1:0]   nb_u;
   logic [WIDTH-1:0]     dp_out;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 wr_bank;

   modport master (
      output rd_en, rd_addr, rd_bank, nb_y, nb_u, wr_en, wr_addr, wr_data, wr_bank,
      input  rd_y, rd_u, dp_out
   );

   modport slave (
      input  rd_en, rd_addr, rd_bank, nb_y, nb_u, wr_en, wr_addr, wr_data, wr_bank,
      output rd_y, rd_u, dp_out
   );
endinterface
`default_nettype wire

// File: rtl/cnn_cell_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : cnn_cell_sequencer
// Purpose  : Drives one shared CNN cell datapath across a ROWS x COLS grid,
//            fetching 3x3 neighbourhoods and ping-ponging the state banks.
//            Optional macro CNN_CONVERGE_EN adds early stop on a steady state.
// Revision : 1.0
// =============================================================================
module cnn_cell_sequencer #(
   parameter int                      WIDTH    = 9,
   parameter int                      ROWS     = 4,
   parameter int                      COLS     = 4,
   parameter int                      AW       = 4,
   parameter logic signed [WIDTH-1:0] BOUNDARY = '0
) (
   input  wire                        clk,
   input  wire                        rst_n,
   input  wire                        start,
   input  wire  [7:0]                 iters,
   output logic                       busy,
   output logic                       done,
   output logic [7:0]                 iter_cnt,
`ifdef CNN_CONVERGE_EN
   output logic                       converged,
`endif
   cnn_cell_sequencer_if.master       bus
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] c_last_row = RW'(ROWS - 1);
   localparam logic [CW-1:0] c_last_col = CW'(COLS - 1);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_fetch = 3'd1;
   localparam logic [2:0] c_last  = 3'd2;
   localparam logic [2:0] c_eval  = 3'd3;
   localparam logic [2:0] c_write = 3'd4;
   localparam logic [2:0] c_swap  = 3'd5;

   logic [2:0]         r_state, w_next;
   logic [3:0]         r_k;
   logic [RW-1:0]      r_row;
   logic [CW-1:0]      r_col;
   logic [AW-1:0]      r_addr;
   logic [7:0]         r_iters, r_iter_cnt;
   logic               r_rd_bank, r_pend, r_zero_done;
   logic [9*WIDTH-1:0] r_nb_y, r_nb_u;
   logic [WIDTH-1:0]   r_wr_data;

   logic               w_up, w_down, w_left, w_right, w_in_grid;
   logic               w_last_cell, w_last_iter, w_stop;
   logic [AW-1:0]      w_nb_addr;
   logic [3:0]         w_cap_slot;
   logic               w_rd_en, w_wr_en, w_done;
   logic [AW-1:0]      w_rd_addr, w_wr_addr;

   // Slot k covers row offset k/3-1 and column offset k%3-1.
   assign w_up      = (r_k < 4'd3);
   assign w_down    = (r_k > 4'd5);
   assign w_left    = (r_k == 4'd0) || (r_k == 4'd3) || (r_k == 4'd6);
   assign w_right   = (r_k == 4'd2) || (r_k == 4'd5) || (r_k == 4'd8);
   assign w_in_grid = !(w_up    && (r_row == '0))       &&
                      !(w_down  && (r_row == c_last_row)) &&
                      !(w_left  && (r_col == '0))       &&
                      !(w_right && (r_col == c_last_col));
   assign w_nb_addr = r_addr
                    + (w_down  ? AW'(COLS) : AW'(0)) - (w_up   ? AW'(COLS) : AW'(0))
                    + (w_right ? AW'(1)    : AW'(0)) - (w_left ? AW'(1)    : AW'(0));
   assign w_cap_slot  = r_k - 4'd1;
   assign w_last_cell = (r_row == c_last_row) && (r_col == c_last_col);
   assign w_last_iter = ((r_iter_cnt + 8'd1) == r_iters);

`ifdef CNN_CONVERGE_EN
   logic r_changed, r_converged;
   assign w_stop    = w_last_iter || !r_changed;
   assign converged = r_converged;
`else
   assign w_stop    = w_last_iter;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_idle;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (start && (iters != 8'd0)) w_next = c_fetch;
         c_fetch: if (r_k == 4'd8) w_next = c_last;
         c_last:  w_next = c_eval;
         c_eval:  w_next = c_write;
         c_write: w_next = w_last_cell ? c_swap : c_fetch;
         c_swap:  w_next = w_stop ? c_idle : c_fetch;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      w_rd_en   = 1'b0;
      w_rd_addr = '0;
      w_wr_en   = 1'b0;
      w_wr_addr = '0;
      w_done    = r_zero_done;
      case (r_state)
         c_fetch: begin
            w_rd_en   = w_in_grid;
            w_rd_addr = w_in_grid ? w_nb_addr : '0;
         end
         c_write: begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_addr;
         end
         c_swap:  w_done = w_stop;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k         <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_addr      <= '0;
         r_iters     <= '0;
         r_iter_cnt  <= '0;
         r_rd_bank   <= 1'b0;
         r_pend      <= 1'b0;
         r_zero_done <= 1'b0;
         r_nb_y      <= '0;
         r_nb_u      <= '0;
         r_wr_data   <= '0;
`ifdef CNN_CONVERGE_EN
         r_changed   <= 1'b0;
         r_converged <= 1'b0;
`endif
      end else begin
         r_pend      <= (r_state == c_fetch) && w_in_grid;
         r_zero_done <= 1'b0;
         // Read data lags its strobe by one cycle, so slot k-1 lands during k.
         if (r_pend && ((r_state == c_fetch) || (r_state == c_last))) begin
            r_nb_y[int'(w_cap_slot)*WIDTH +: WIDTH] <= bus.rd_y;
            r_nb_u[int'(w_cap_slot)*WIDTH +: WIDTH] <= bus.rd_u;
         end
         case (r_state)
            c_idle: if (start) begin
               r_iters     <= iters;
               r_iter_cnt  <= '0;
               r_k         <= '0;
               r_row       <= '0;
               r_col       <= '0;
               r_addr      <= '0;
               r_zero_done <= (iters == 8'd0);
`ifdef CNN_CONVERGE_EN
               r_changed   <= 1'b0;
               r_converged <= 1'b0;
`endif
            end
            c_fetch: begin
               r_k <= r_k + 4'd1;
               if (!w_in_grid) begin
                  r_nb_y[int'(r_k)*WIDTH +: WIDTH] <= BOUNDARY;
                  r_nb_u[int'(r_k)*WIDTH +: WIDTH] <= BOUNDARY;
               end
            end
            c_eval: r_wr_data <= bus.dp_out;
            c_write: begin
               r_k    <= '0;
               r_addr <= w_last_cell ? '0 : r_addr + AW'(1);
               if (r_col == c_last_col) begin
                  r_col <= '0;
                  r_row <= (r_row == c_last_row) ? '0 : r_row + RW'(1);
               end else begin
                  r_col <= r_col + CW'(1);
               end
`ifdef CNN_CONVERGE_EN
               if (r_wr_data != r_nb_y[4*WIDTH +: WIDTH]) r_changed <= 1'b1;
`endif
            end
            c_swap: begin
               r_rd_bank  <= ~r_rd_bank;
               r_iter_cnt <= r_iter_cnt + 8'd1;
`ifdef CNN_CONVERGE_EN
               r_changed  <= 1'b0;
               if (!r_changed) r_converged <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != c_idle);
   assign done        = w_done;
   assign iter_cnt    = r_iter_cnt;
   assign bus.rd_en   = w_rd_en;
   assign bus.rd_addr = w_rd_addr;
   assign bus.rd_bank = r_rd_bank;
   assign bus.nb_y    = r_nb_y;
   assign bus.nb_u    = r_nb_u;
   assign bus.wr_en   = w_wr_en;
   assign bus.wr_addr = w_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.wr_bank = ~r_rd_bank;
endmodule
`default_nettype wire

// File: tb/tb_cnn_cell_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_cnn_cell_sequencer
// Purpose  : Random grids and iteration counts checked against an array-level
//            CNN iteration model with Dirichlet boundary.
// Revision : 1.0
// =============================================================================
module tb_cnn_cell_sequencer;
   localparam int W  = 9;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int AW = 4;
   localparam int N  = R * C;
   localparam int CYC_ITER = 12 * N + 1;
   localparam logic [W-1:0] BND = 9'h1FD;   // -3

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] iters = 8'd0;
   logic       busy, done;
   logic [7:0] iter_cnt;
`ifdef CNN_CONVERGE_EN
   logic       converged;
`endif

   cnn_cell_sequencer_if #(.WIDTH(W), .AW(AW)) bus ();

   cnn_cell_sequencer #(.WIDTH(W), .ROWS(R), .COLS(C), .AW(AW), .BOUNDARY(BND)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .iters    (iters),
      .busy     (busy),
      .done     (done),
      .iter_cnt (iter_cnt),
`ifdef CNN_CONVERGE_EN
      .converged(converged),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem_y [2][N];
   logic [W-1:0] mem_u [N];
   logic [W-1:0] ref_y [N];
   logic [W-1:0] tmp_y [N];
   int mode = 0;
   int n_assert = 0, n_fail = 0;
   int n_rd = 0, n_wr = 0, n_coll = 0, n_busy = 0, n_done = 0;
   int exp_rd = 0;

   // External datapath: 0 const 5, 1 centre+1, 2 centre, 3 sum of Y plus centre U.
   function automatic logic [W-1:0] dp_fn(int m, logic [9*W-1:0] y, logic [9*W-1:0] u);
      logic [W-1:0] s;
      s = '0;
      case (m)
         0: s = 9'd5;
         1: s = y[4*W +: W] + 9'd1;
         2: s = y[4*W +: W];
         default: begin
            for (int k = 0; k < 9; k++) s = s + y[k*W +: W];
            s = s + u[4*W +: W];
         end
      endcase
      return s;
   endfunction

   assign bus.dp_out = dp_fn(mode, bus.nb_y, bus.nb_u);

   function automatic int slot_addr(int r, int c, int k);
      int nr, nc;
      nr = r + k / 3 - 1;
      nc = c + k % 3 - 1;
      if (nr < 0 || nr >= R || nc < 0 || nc >= C) return -1;
      return nr * C + nc;
   endfunction

   function automatic logic [W-1:0] cell_rule(int m, logic [W-1:0] sum, logic [W-1:0] cen,
                                              logic [W-1:0] u4);
      case (m)
         0:       return 9'd5;
         1:       return cen + 9'd1;
         2:       return cen;
         default: return sum + u4;
      endcase
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Grid RAMs: one-cycle read latency, write into the next-state bank.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_y <= mem_y[bus.rd_bank][bus.rd_addr];
         bus.rd_u <= mem_u[bus.rd_addr];
      end
      if (bus.wr_en) mem_y[bus.wr_bank][bus.wr_addr] = bus.wr_data;
   end

   int m_a, m_r, m_c, m_sa;
   logic [W-1:0] m_ey, m_eu, m_sum, m_cen, m_u4;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rd_en) n_rd++;
         if (bus.rd_en && bus.wr_en) n_coll++;
         if (busy) n_busy++;
         if (done) n_done++;
         if (bus.wr_en) begin
            m_a = n_wr % N;
            m_r = m_a / C;
            m_c = m_a % C;
            m_sum = '0;
            m_cen = '0;
            m_u4  = '0;
            chk("wr_addr", bus.wr_addr, m_a);
            chk("wr_bank", bus.wr_bank, !bus.rd_bank);
            for (int k = 0; k < 9; k++) begin
               m_sa = slot_addr(m_r, m_c, k);
               m_ey = (m_sa < 0) ? BND : mem_y[bus.rd_bank][m_sa];
               m_eu = (m_sa < 0) ? BND : mem_u[m_sa];
               m_sum = m_sum + m_ey;
               if (k == 4) begin
                  m_cen = m_ey;
                  m_u4  = m_eu;
               end
               chk($sformatf("nb_y[%0d] cell %0d", k, m_a), bus.nb_y[k*W +: W], m_ey);
               chk($sformatf("nb_u[%0d] cell %0d", k, m_a), bus.nb_u[k*W +: W], m_eu);
            end
            chk("wr_data", bus.wr_data, cell_rule(mode, m_sum, m_cen, m_u4));
            n_wr++;
         end
      end
   end

   task automatic clear_cnt();
      n_rd = 0; n_wr = 0; n_coll = 0; n_busy = 0; n_done = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_cnt();
   endtask

   task automatic fill_random();
      for (int a = 0; a < N; a++) begin
         mem_y[0][a] = W'($urandom);
         mem_y[1][a] = W'($urandom);
         mem_u[a]    = W'($urandom);
      end
   endtask

   // Reference: whole-grid synchronous update, repeated it times.
   task automatic model_run(int start_bank, int it, int m);
      logic [W-1:0] s, cen, u4, v;
      int sa;
      for (int a = 0; a < N; a++) ref_y[a] = mem_y[start_bank][a];
      for (int i = 0; i < it; i++) begin
         for (int a = 0; a < N; a++) begin
            s = '0; cen = '0; u4 = '0;
            for (int k = 0; k < 9; k++) begin
               sa = slot_addr(a / C, a % C, k);
               v  = (sa < 0) ? BND : ref_y[sa];
               s  = s + v;
               if (k == 4) begin
                  cen = v;
                  u4  = mem_u[a];
               end
            end
            tmp_y[a] = cell_rule(m, s, cen, u4);
         end
         for (int a = 0; a < N; a++) ref_y[a] = tmp_y[a];
      end
   endtask

   task automatic run(int it, bit poke);
      int cyc;
      @(negedge clk);
      iters = 8'(it);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (cyc = 0; cyc < 20000; cyc++) begin
         if (done) break;
         start = (poke && cyc == 40);
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      chk("busy_at_done", busy, 1'b1);
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
      chk("done_one_cycle", done, 1'b0);
   endtask

   task automatic check_run(string tag, int it, int bank_final);
      chk({tag, " iter_cnt"}, iter_cnt, it);
      chk({tag, " rd_bank"}, bus.rd_bank, bank_final);
      chk({tag, " busy_cycles"}, n_busy, it * CYC_ITER);
      chk({tag, " done_count"}, n_done, 1);
      chk({tag, " rd_count"}, n_rd, it * exp_rd);
      chk({tag, " wr_count"}, n_wr, it * N);
      chk({tag, " rd_wr_overlap"}, n_coll, 0);
      for (int a = 0; a < N; a++)
         chk($sformatf("%s final[%0d]", tag, a), mem_y[bank_final][a], ref_y[a]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int it;
      int guard;
      for (int a = 0; a < N; a++)
         for (int k = 0; k < 9; k++)
            if (slot_addr(a / C, a % C, k) >= 0) exp_rd++;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst iter_cnt", iter_cnt, 8'd0);
      chk("rst rd_en", bus.rd_en, 1'b0);
      chk("rst wr_en", bus.wr_en, 1'b0);
      chk("rst rd_addr", bus.rd_addr, 0);
      chk("rst wr_addr", bus.wr_addr, 0);
      chk("rst wr_data", bus.wr_data, 0);
      chk("rst rd_bank", bus.rd_bank, 1'b0);
      chk("rst wr_bank", bus.wr_bank, 1'b1);
      chk("rst nb_y", bus.nb_y, 0);
      chk("rst nb_u", bus.nb_u, 0);
`ifdef CNN_CONVERGE_EN
      chk("rst converged", converged, 1'b0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Constant datapath, zero memory, one iteration
      for (int a = 0; a < N; a++) begin
         mem_y[0][a] = '0; mem_y[1][a] = '0; mem_u[a] = '0;
      end
      mode = 0;
      clear_cnt();
      model_run(0, 1, 0);
      run(1, 1'b0);
      check_run("const5", 1, 1);

      // Increment datapath, three iterations from zero
      do_reset();
      for (int a = 0; a < N; a++) mem_y[0][a] = '0;
      mode = 1;
      model_run(0, 3, 1);
      run(3, 1'b0);
      check_run("incr3", 3, 1);
      for (int a = 0; a < N; a++) chk("incr3 value3", mem_y[1][a], 9'd3);

      // Zero iterations: immediate done, no traffic
      do_reset();
      @(negedge clk);
      iters = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero done", done, 1'b1);
      chk("zero busy", busy, 1'b0);
      @(negedge clk);
      chk("zero done_pulse", done, 1'b0);
      repeat (3) @(negedge clk);
      chk("zero rd_count", n_rd, 0);
      chk("zero wr_count", n_wr, 0);
      chk("zero busy_cycles", n_busy, 0);
      chk("zero iter_cnt", iter_cnt, 8'd0);

      // Random grids through the neighbourhood-sum datapath
      for (int t = 0; t < 3; t++) begin
         do_reset();
         fill_random();
         mode = 3;
         it = $urandom_range(1, 4);
         model_run(0, it, 3);
         run(it, t == 0);
         check_run($sformatf("rand%0d", t), it, it % 2);
      end

      // Reset during FETCH of cell 7 in the second iteration
      do_reset();
      fill_random();
      mode = 3;
      @(negedge clk);
      iters = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!(bus.wr_en && bus.wr_addr == 4'd6 && iter_cnt == 8'd1) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      chk("midrst reached", guard < 5000, 1'b1);
      repeat (2) @(negedge clk);
      chk("midrst pre busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", busy, 1'b0);
      chk("midrst rd_en", bus.rd_en, 1'b0);
      chk("midrst wr_en", bus.wr_en, 1'b0);
      chk("midrst rd_addr", bus.rd_addr, 0);
      chk("midrst iter_cnt", iter_cnt, 8'd0);
      chk("midrst rd_bank", bus.rd_bank, 1'b0);
      chk("midrst nb_y", bus.nb_y, 0);
      chk("midrst wr_data", bus.wr_data, 0);
      repeat (3) begin
         @(negedge clk);
         chk("midrst quiet", {bus.rd_en, bus.wr_en}, 2'b00);
      end
      rst_n = 1'b1;
      @(negedge clk);
      clear_cnt();
      model_run(0, 2, 3);
      run(2, 1'b0);
      check_run("after_rst", 2, 0);

      // Steady-state datapath
      do_reset();
      fill_random();
      mode = 2;
`ifdef CNN_CONVERGE_EN
      model_run(0, 1, 2);
      run(10, 1'b0);
      check_run("steady", 1, 1);
      chk("steady converged", converged, 1'b1);
      clear_cnt();
      mode = 1;
      model_run(1, 2, 1);
      fork
         run(2, 1'b0);
         begin
            repeat (3) @(negedge clk);
            chk("converged cleared", converged, 1'b0);
         end
      join
      chk("incr converged", converged, 1'b0);
      check_run("post_conv", 2, 1);
`else
      model_run(0, 10, 2);
      run(10, 1'b0);
      check_run("steady", 10, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
